eth_rx_ethertype_demux: RTL and testbench

Receive-side dispatch stage between the Ethernet deframer and the protocol engines (ARP, IPv4). It consumes the packed, header-stripped AXIS stream plus its MAC/ethertype sideband. It filters on destination MAC, steers each whole packet to an ARP or IPv4 output port, and silently drops everything else. A one-register output stage gives a one-cycle latency, and the source MAC is carried forward for the ARP/IP engines.

---
 rtl/eth_rx_ethertype_demux.sv | 170 +++++++++++++++++
 tb/tb_eth_rx_ethertype_demux.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_ethertype_demux.sv
// Receive dispatch: filters on destination MAC and steers whole packets
// to the ARP or IPv4 engine through one shared output register.
module eth_rx_ethertype_demux #(
    parameter int          AXIS_BYTES  = 4,
    parameter logic [47:0] OUR_MAC     = 48'h070605040302,
    parameter bit          PROMISCUOUS = 1'b0
) (
    input  logic                    clk,
    input  logic                    sresetn,

    output logic                    axis_i_tready,
    input  logic                    axis_i_tvalid,
    input  logic                    axis_i_tlast,
    input  logic [AXIS_BYTES-1:0]   axis_i_tkeep,
    input  logic [8*AXIS_BYTES-1:0] axis_i_tdata,
    input  logic [47:0]             axis_i_dst_mac,
    input  logic [47:0]             axis_i_src_mac,
    input  logic [15:0]             axis_i_ethertype,

    input  logic                    axis_arp_tready,
    output logic                    axis_arp_tvalid,
    output logic                    axis_arp_tlast,
    output logic [AXIS_BYTES-1:0]   axis_arp_tkeep,
    output logic [8*AXIS_BYTES-1:0] axis_arp_tdata,
    output logic [47:0]             axis_arp_src_mac,

    input  logic                    axis_ip_tready,
    output logic                    axis_ip_tvalid,
    output logic                    axis_ip_tlast,
    output logic [AXIS_BYTES-1:0]   axis_ip_tkeep,
    output logic [8*AXIS_BYTES-1:0] axis_ip_tdata,
    output logic [47:0]             axis_ip_src_mac,

    output logic [15:0]             drop_count
);

    localparam int DW = 8 * AXIS_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        FWD_ARP,
        FWD_IP,
        DROP
    } state_t;

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [AXIS_BYTES-1:0] out_keep_q, out_keep_d;
    logic [DW-1:0]         out_data_q, out_data_d;
    logic                  sel_ip_q, sel_ip_d;
    logic [47:0]           arp_src_q, arp_src_d;
    logic [47:0]           ip_src_q, ip_src_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic mac_ok;
    logic is_arp;
    logic is_ip;
    logic first;
    logic fwd;
    logic to_ip;
    logic sel_tready;
    logic can_load;
    logic accept;

    always_comb begin
        mac_ok = PROMISCUOUS
              || axis_i_dst_mac[0]
              || (axis_i_dst_mac == OUR_MAC);
        is_arp = mac_ok && (axis_i_ethertype == 16'h0806);
        is_ip  = mac_ok && (axis_i_ethertype == 16'h0800);

        first = 1'b0;
        fwd   = 1'b0;
        to_ip = 1'b0;
        case (state_q)
            IDLE: begin
                first = 1'b1;
                fwd   = is_arp || is_ip;
                to_ip = is_ip;
            end
            FWD_ARP: fwd = 1'b1;
            FWD_IP: begin
                fwd   = 1'b1;
                to_ip = 1'b1;
            end
            default: fwd = 1'b0;
        endcase

        sel_tready = sel_ip_q ? axis_ip_tready : axis_arp_tready;
        can_load   = !out_valid_q || sel_tready;
        // Discarded beats never wait behind a stalled beat for the other port.
        axis_i_tready = fwd ? can_load : 1'b1;
        accept = axis_i_tvalid && axis_i_tready;

        state_d     = state_q;
        out_valid_d = out_valid_q && !sel_tready;
        out_last_d  = out_last_q;
        out_keep_d  = out_keep_q;
        out_data_d  = out_data_q;
        sel_ip_d    = sel_ip_q;
        arp_src_d   = arp_src_q;
        ip_src_d    = ip_src_q;
        drop_cnt_d  = drop_cnt_q;

        if (accept) begin
            if (fwd) begin
                out_valid_d = 1'b1;
                out_last_d  = axis_i_tlast;
                out_keep_d  = axis_i_tkeep;
                out_data_d  = axis_i_tdata;
                sel_ip_d    = to_ip;
                if (first && to_ip) begin
                    ip_src_d = axis_i_src_mac;
                end else if (first) begin
                    arp_src_d = axis_i_src_mac;
                end
            end else if (first && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end

            if (axis_i_tlast) begin
                state_d = IDLE;
            end else if (first) begin
                state_d = !fwd  ? DROP
                        : to_ip ? FWD_IP
                        : FWD_ARP;
            end
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_keep_q  <= '0;
            out_data_q  <= '0;
            sel_ip_q    <= 1'b0;
            arp_src_q   <= '0;
            ip_src_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_keep_q  <= out_keep_d;
            out_data_q  <= out_data_d;
            sel_ip_q    <= sel_ip_d;
            arp_src_q   <= arp_src_d;
            ip_src_q    <= ip_src_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign axis_arp_tvalid  = out_valid_q && !sel_ip_q;
    assign axis_arp_tlast   = out_last_q;
    assign axis_arp_tkeep   = out_keep_q;
    assign axis_arp_tdata   = out_data_q;
    assign axis_arp_src_mac = arp_src_q;

    assign axis_ip_tvalid   = out_valid_q && sel_ip_q;
    assign axis_ip_tlast    = out_last_q;
    assign axis_ip_tkeep    = out_keep_q;
    assign axis_ip_tdata    = out_data_q;
    assign axis_ip_src_mac  = ip_src_q;

    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_ethertype_demux.sv
// Directed bench for eth_rx_ethertype_demux: vector table plus
// packet-level sequences for stalls, filtering, reset and saturation.
module tb_eth_rx_ethertype_demux;

    localparam logic [47:0] OURS  = 48'h070605040302;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        sresetn;
    logic        i_tready, tv, tl;
    logic [3:0]  tk;
    logic [31:0] td;
    logic [47:0] dst, src;
    logic [15:0] et;
    logic        arp_rdy, arp_v, arp_l;
    logic [3:0]  arp_k;
    logic [31:0] arp_d;
    logic [47:0] arp_src;
    logic        ip_rdy, ip_v, ip_l;
    logic [3:0]  ip_k;
    logic [31:0] ip_d;
    logic [47:0] ip_src;
    logic [15:0] drop_cnt;

    logic        p_tready, p_arp_v, p_arp_l, p_ip_v, p_ip_l;
    logic [3:0]  p_arp_k, p_ip_k;
    logic [31:0] p_arp_d, p_ip_d;
    logic [47:0] p_arp_src, p_ip_src;
    logic [15:0] p_drop;

    always #5 clk = ~clk;

    eth_rx_ethertype_demux dut (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tready(i_tready), .axis_i_tvalid(tv),
        .axis_i_tlast(tl), .axis_i_tkeep(tk),
        .axis_i_tdata(td), .axis_i_dst_mac(dst),
        .axis_i_src_mac(src), .axis_i_ethertype(et),
        .axis_arp_tready(arp_rdy), .axis_arp_tvalid(arp_v),
        .axis_arp_tlast(arp_l), .axis_arp_tkeep(arp_k),
        .axis_arp_tdata(arp_d), .axis_arp_src_mac(arp_src),
        .axis_ip_tready(ip_rdy), .axis_ip_tvalid(ip_v),
        .axis_ip_tlast(ip_l), .axis_ip_tkeep(ip_k),
        .axis_ip_tdata(ip_d), .axis_ip_src_mac(ip_src),
        .drop_count(drop_cnt)
    );

    eth_rx_ethertype_demux #(.PROMISCUOUS(1'b1)) dut_p (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tready(p_tready), .axis_i_tvalid(tv),
        .axis_i_tlast(tl), .axis_i_tkeep(tk),
        .axis_i_tdata(td), .axis_i_dst_mac(dst),
        .axis_i_src_mac(src), .axis_i_ethertype(et),
        .axis_arp_tready(arp_rdy), .axis_arp_tvalid(p_arp_v),
        .axis_arp_tlast(p_arp_l), .axis_arp_tkeep(p_arp_k),
        .axis_arp_tdata(p_arp_d), .axis_arp_src_mac(p_arp_src),
        .axis_ip_tready(ip_rdy), .axis_ip_tvalid(p_ip_v),
        .axis_ip_tlast(p_ip_l), .axis_ip_tkeep(p_ip_k),
        .axis_ip_tdata(p_ip_d), .axis_ip_src_mac(p_ip_src),
        .drop_count(p_drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t arp_q[$];
    beat_t ip_q[$];
    int    p_arp_n = 0;
    logic        hold_v = 1'b0;
    logic [36:0] hold_b;

    // Transfers complete at the next posedge; everything is stable here.
    always @(negedge clk) begin
        if (arp_v && arp_rdy) arp_q.push_back('{arp_d, arp_k, arp_l});
        if (ip_v && ip_rdy) ip_q.push_back('{ip_d, ip_k, ip_l});
        if (p_arp_v && arp_rdy) p_arp_n++;
        if (hold_v && ip_v) chk("ip_hold", {27'd0, ip_d, ip_k, ip_l},
                                {27'd0, hold_b});
        hold_v = ip_v && !ip_rdy;
        hold_b = {ip_d, ip_k, ip_l};
    end

    typedef struct {
        logic        v;
        logic        l;
        logic [31:0] d;
        logic [47:0] dm;
        logic [47:0] sm;
        logic [15:0] e;
        logic        ar;
        logic        ir;
        logic        x_rdy;
        logic        x_av;
        logic        x_iv;
        logic [31:0] x_d;
    } vec_t;

    vec_t vt[9];

    task automatic send_pkt(input logic [47:0] dm, input logic [47:0] sm,
                            input logic [15:0] e, input int n,
                            input logic [3:0] lk, input logic [31:0] base,
                            input bit tog, output int stalls);
        int   guard;
        logic done;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            tv = 1'b1;
            tl = (i == n - 1);
            tk = (i == n - 1) ? lk : 4'hF;
            td = base + i;
            dst = dm;
            src = sm;
            et = e;
            guard = 0;
            done = 1'b0;
            while (!done) begin
                if (tog) ip_rdy = ~ip_rdy;
                @(negedge clk);
                done = i_tready;
                @(posedge clk);
                #1;
                if (!done) begin
                    stalls++;
                    guard++;
                    if (guard > 50) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL send_timeout: beat %0d not accepted", i);
                        done = 1'b1;
                    end
                end
            end
        end
        tv = 1'b0;
        tl = 1'b0;
        ip_rdy = 1'b1;
        arp_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    int st;

    initial begin
        vt[0] = '{1, 1, 32'hA0, BCAST, 48'h1, 16'h0806, 1, 1, 1, 1, 0, 32'hA0};
        vt[1] = '{1, 1, 32'hB1, BCAST, 48'h2, 16'h0800, 1, 1, 1, 0, 1, 32'hB1};
        vt[2] = '{1, 1, 32'hC2, BCAST, 48'h3, 16'h86DD, 1, 1, 1, 0, 0, 32'h0};
        vt[3] = '{1, 1, 32'hD3, BCAST, 48'h4, 16'h0806, 1, 1, 1, 1, 0, 32'hD3};
        vt[4] = '{1, 1, 32'hE4, BCAST, 48'h5, 16'h0800, 1, 1, 1, 0, 1, 32'hE4};
        vt[5] = '{1, 1, 32'hF5, BCAST, 48'h6, 16'h0806, 1, 0, 0, 0, 1, 32'hE4};
        vt[6] = '{1, 1, 32'h77, BCAST, 48'h7, 16'h86DD, 1, 0, 1, 0, 1, 32'hE4};
        vt[7] = '{1, 1, 32'hF5, BCAST, 48'h8, 16'h0806, 1, 1, 1, 1, 0, 32'hF5};
        vt[8] = '{0, 0, 32'h0, 48'h0, 48'h0, 16'h0, 1, 1, 1, 0, 0, 32'h0};

        sresetn = 1'b0;
        {tv, tl, tk, td, dst, src, et} = '0;
        arp_rdy = 1'b1;
        ip_rdy = 1'b1;
        repeat (2) @(negedge clk);
        sresetn = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_arp_v", arp_v, 0);
        chk("rst_ip_v", ip_v, 0);
        chk("rst_data", {arp_d, arp_k, arp_l}, 0);
        chk("rst_src", {arp_src, ip_src}, 0);
        chk("rst_drop", drop_cnt, 0);

        // Single-beat packets back to back, including stall and drop-past-stall.
        foreach (vt[i]) begin
            tv = vt[i].v;
            tl = vt[i].l;
            tk = 4'hF;
            td = vt[i].d;
            dst = vt[i].dm;
            src = vt[i].sm;
            et = vt[i].e;
            arp_rdy = vt[i].ar;
            ip_rdy = vt[i].ir;
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", i), i_tready, vt[i].x_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_arp_v", i), arp_v, vt[i].x_av);
            chk($sformatf("vec%0d_ip_v", i), ip_v, vt[i].x_iv);
            if (vt[i].x_av || vt[i].x_iv)
                chk($sformatf("vec%0d_data", i), arp_d, vt[i].x_d);
        end
        chk("vec_arp_src", arp_src, 48'h8);
        chk("vec_ip_src", ip_src, 48'h5);
        chk("vec_drop", drop_cnt, 2);
        chk("vec_p_drop", p_drop, 2);

        // Broadcast ARP, 11 beats with a partial last beat.
        arp_q.delete();
        ip_q.delete();
        send_pkt(BCAST, 48'h112233445566, 16'h0806, 11, 4'b0011,
                 32'h1000, 1'b0, st);
        chk("t1_count", arp_q.size(), 11);
        for (int i = 0; i < 11 && i < arp_q.size(); i++)
            chk($sformatf("t1_beat%0d", i),
                {arp_q[i].d, arp_q[i].k, arp_q[i].l},
                {32'h1000 + i, (i == 10) ? 4'b0011 : 4'hF, i == 10});
        chk("t1_ip_none", ip_q.size(), 0);
        chk("t1_src", arp_src, 48'h112233445566);

        // Unicast IPv4 to us with a toggling sink.
        arp_q.delete();
        send_pkt(OURS, 48'hAABBCCDDEEFF, 16'h0800, 5, 4'hF,
                 32'h2000, 1'b1, st);
        chk("t2_count", ip_q.size(), 5);
        for (int i = 0; i < 5 && i < ip_q.size(); i++)
            chk($sformatf("t2_beat%0d", i),
                {ip_q[i].d, ip_q[i].k, ip_q[i].l},
                {32'h2000 + i, 4'hF, i == 4});
        chk("t2_drop", drop_cnt, 2);
        chk("t2_src", ip_src, 48'hAABBCCDDEEFF);
        chk("t2_arp_none", arp_q.size(), 0);

        // Filtered packets; the promiscuous instance takes the first one.
        ip_q.delete();
        p_arp_n = 0;
        send_pkt(48'h0A0B0C0D0E0E, 48'h1, 16'h0806, 3, 4'hF,
                 32'h3000, 1'b0, st);
        chk("t3_stall_a", st, 0);
        send_pkt(BCAST, 48'h2, 16'h86DD, 2, 4'hF, 32'h3100, 1'b0, st);
        chk("t3_stall_b", st, 0);
        chk("t3_out", arp_q.size() + ip_q.size(), 0);
        chk("t3_drop", drop_cnt, 4);
        chk("t3_p_arp", p_arp_n, 3);
        chk("t3_p_drop", p_drop, 3);

        // Reset in the middle of a 6-beat IPv4 packet.
        tv = 1'b1;
        tl = 1'b0;
        tk = 4'hF;
        dst = OURS;
        src = 48'h5;
        et = 16'h0800;
        for (int i = 0; i < 3; i++) begin
            td = 32'h4000 + i;
            @(posedge clk);
            #1;
        end
        chk("t5_pre_v", ip_v, 1);
        tv = 1'b0;
        #2;
        sresetn = 1'b0;
        #1;
        chk("t5_ip_v", ip_v, 0);
        chk("t5_drop", drop_cnt, 0);
        @(negedge clk);
        sresetn = 1'b1;
        @(posedge clk);
        #1;
        arp_q.delete();
        ip_q.delete();
        send_pkt(BCAST, 48'h9, 16'h0806, 2, 4'hF, 32'h5000, 1'b0, st);
        chk("t5_arp_n", arp_q.size(), 2);
        for (int i = 0; i < 2 && i < arp_q.size(); i++)
            chk($sformatf("t5_beat%0d", i),
                {arp_q[i].d, arp_q[i].l}, {32'h5000 + i, i == 1});
        chk("t5_ip_none", ip_q.size(), 0);

        // Saturation: 65537 single-beat drops.
        tv = 1'b1;
        tl = 1'b1;
        dst = BCAST;
        et = 16'h86DD;
        repeat (65534) @(posedge clk);
        #1;
        chk("t6_fffe", drop_cnt, 16'hFFFE);
        @(posedge clk);
        #1;
        chk("t6_ffff", drop_cnt, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_hold", drop_cnt, 16'hFFFF);
        chk("t6_p_hold", p_drop, 16'hFFFF);
        tv = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
